// File: rtl/mult_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
package mult_pkg;

    // Controller states: waiting for work, iterating one bit per clock, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Iteration counter width: it counts WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

    // Full product width.
    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/seq_shift_add_mult_if.sv
// Request/result bundle between a datapath client (master) and the multiplier (slave).
interface seq_shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output start, x, y,
        input  ready, busy, done, product
    );

    modport slave (
        input  start, x, y,
        output ready, busy, done, product
    );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Sequencing FSM and iteration counter for the shift-add multiplier.
// Issues load on acceptance, step on every iteration, finish on the last one.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic start,
    output logic load,
    output logic step,
    output logic finish,
    output logic ready,
    output logic done
);

    localparam int CW = cnt_width(WIDTH);

    mult_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last;

    assign last = (cnt_q == '0);

    // State and counter registers.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, counter update and Moore/strobe outputs.
    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        ready   = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q - 1'b1;
                if (last) begin
                    finish  = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH+2 cycles per op.
// Signed mode multiplies magnitudes and negates the final product when signs differ.
module seq_shift_add_mult
    import mult_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    seq_shift_add_mult_if.slave  bus
);

    localparam int PW = prod_width(WIDTH);

    logic load, step, finish, ready, done;

    mult_seq_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .start  (bus.start),
        .load   (load),
        .step   (step),
        .finish (finish),
        .ready  (ready),
        .done   (done)
    );

    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             neg_q, neg_d;
    logic [PW-1:0]    product_q, product_d;

    logic [WIDTH-1:0] mag_x, mag_y;
    logic             op_neg;
    logic [WIDTH:0]   sum;
    logic [PW-1:0]    step_prod;
    logic [PW-1:0]    final_prod;

    // Operand conditioning: magnitudes and result sign in signed mode, raw operands otherwise.
    // The most negative value's magnitude 2^(WIDTH-1) still fits WIDTH unsigned bits.
    generate
        if (SIGNED) begin : g_signed
            assign mag_x  = bus.x[WIDTH-1] ? -bus.x : bus.x;
            assign mag_y  = bus.y[WIDTH-1] ? -bus.y : bus.y;
            assign op_neg = bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
        end else begin : g_unsigned
            assign mag_x  = bus.x;
            assign mag_y  = bus.y;
            assign op_neg = 1'b0;
        end
    endgenerate

    // One iteration: conditional add into {C,A}, then shift {C,A,Q} right by one.
    assign sum        = {1'b0, a_q} + {1'b0, (q_q[0] ? m_q : '0)};
    assign step_prod  = {sum, q_q[WIDTH-1:1]};
    assign final_prod = neg_q ? -step_prod : step_prod;

    // Datapath next-state: load operands, iterate, capture product on the last iteration.
    always_comb begin
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        neg_d     = neg_q;
        product_d = product_q;
        if (load) begin
            m_d   = mag_x;
            q_d   = mag_y;
            a_d   = '0;
            neg_d = op_neg;
        end else if (step) begin
            a_d = step_prod[PW-1:WIDTH];
            q_d = step_prod[WIDTH-1:0];
            if (finish) begin
                product_d = final_prod;
            end
        end
    end

    // Datapath registers.
    // NOTE: every datapath flop, including the held product, is reset so an aborted op leaves no residue.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            neg_q     <= neg_d;
            product_q <= product_d;
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = ~ready;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule
